// File: rtl/prio_irq_pkg.sv
// prio_irq_pkg: shared types and helpers for the latched priority encoder.
//   state_e      : delivery FSM states (IDLE, PRESENT)
//   highest_idx  : index of the most significant set bit (0 for an all-zero vector)
package prio_irq_pkg;

  localparam int unsigned PRIO_WIDTH_IN  = 8;
  localparam int unsigned PRIO_WIDTH_OUT = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic logic [PRIO_WIDTH_OUT-1:0] highest_idx(
    input logic [PRIO_WIDTH_IN-1:0] vec
  );
    logic [PRIO_WIDTH_OUT-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(PRIO_WIDTH_IN); i++) begin
      if (vec[i]) idx = PRIO_WIDTH_OUT'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// prio_find_first: combinational MSB-first leading-one detector.
//   vec_i [WIDTH_IN]  : input vector
//   any_o             : at least one bit of vec_i is set
//   idx_o [WIDTH_OUT] : index of the highest set bit (0 when vec_i is zero)
module prio_find_first #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 3
) (
  input  logic [WIDTH_IN-1:0]  vec_i,
  output logic                 any_o,
  output logic [WIDTH_OUT-1:0] idx_o
);

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    any_o = |vec_i;
    idx_o = '0;
    for (int i = 0; i < WIDTH_IN; i++) begin
      if (vec_i[i]) idx_o = WIDTH_OUT'(i);
    end
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// prio_irq_encoder: clocked, cascadable priority encoder with latched requests.
// Falling edges on the active-low request lines set pending bits; the highest
// eligible pending index is presented inverted on y_bar with a vld/rdy handshake.
// 74148-style ei_bar/eo_bar/gs_bar cascade pins are derived from registered state.
//   clk, rst_n : clock, async active-low reset
//   ei_bar     : cascade enable in (active-low), gates loading and gs/eo
//   req_bar    : request lines, active-low, synchronous to clk
//   rdy        : consumer accepts y_bar while vld=1
//   clr_ovf    : clears the sticky overrun flag
//   mask       : (only with PRIO_MASK_EN) 1 excludes a line from arbitration
//   vld, y_bar : valid flag and inverted winning index
//   gs_bar     : 0 = enabled and something eligible
//   eo_bar     : 0 = enabled and nothing eligible
//   ovf        : sticky, a fall hit an already pending bit
// Build option: define PRIO_MASK_EN to add the mask input.
//
// state   | meaning
// IDLE    | vld=0, load highest eligible index when enabled
// PRESENT | vld=1, y_bar frozen until rdy
module prio_irq_encoder
  import prio_irq_pkg::*;
#(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ei_bar,
  input  logic [WIDTH_IN-1:0]  req_bar,
  input  logic                 rdy,
  input  logic                 clr_ovf,
`ifdef PRIO_MASK_EN
  input  logic [WIDTH_IN-1:0]  mask,
`endif
  output logic                 vld,
  output logic [WIDTH_OUT-1:0] y_bar,
  output logic                 gs_bar,
  output logic                 eo_bar,
  output logic                 ovf
);

  if (WIDTH_OUT != $clog2(WIDTH_IN)) begin : g_bad_width
    $error("prio_irq_encoder: WIDTH_OUT must equal clog2(WIDTH_IN)");
  end

  state_e                state_q, state_d;
  logic [WIDTH_IN-1:0]   req_q, pending_q, pending_d;
  logic [WIDTH_IN-1:0]   fall, clr_vec, eligible;
  logic [WIDTH_OUT-1:0]  y_bar_q, y_bar_d, idx_win, idx_cur;
  logic                  any_elig;
  logic                  ovf_q, ovf_d;

`ifdef PRIO_MASK_EN
  assign eligible = pending_q & ~mask;
`else
  assign eligible = pending_q;
`endif

  prio_find_first #(
    .WIDTH_IN  (WIDTH_IN),
    .WIDTH_OUT (WIDTH_OUT)
  ) u_find_first (
    .vec_i (eligible),
    .any_o (any_elig),
    .idx_o (idx_win)
  );

  // Capture and pending bookkeeping.
  always_comb begin
    fall    = req_q & ~req_bar;
    idx_cur = ~y_bar_q;
    clr_vec = '0;
    if (state_q == PRESENT && rdy) clr_vec[idx_cur] = 1'b1;
    // A fall in the same cycle as the clear re-pends the bit.
    pending_d = (pending_q & ~clr_vec) | fall;
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    // A bit being cleared this cycle is not an overrun; a real overrun beats clr_ovf.
    if (|(fall & pending_q & ~clr_vec)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '1;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      req_q     <= req_bar;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  // FSM state register (y_bar is loaded together with the transition).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_bar_q <= '1;
    end else begin
      state_q <= state_d;
      y_bar_q <= y_bar_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    y_bar_d = y_bar_q;
    case (state_q)
      IDLE: begin
        if (!ei_bar && any_elig) begin
          state_d = PRESENT;
          y_bar_d = ~idx_win;
        end
      end
      PRESENT: begin
        if (rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and cascade outputs.
  always_comb begin
    vld    = (state_q == PRESENT);
    y_bar  = y_bar_q;
    gs_bar = ~(!ei_bar & any_elig);
    eo_bar = ~(!ei_bar & ~any_elig);
    ovf    = ovf_q;
  end

endmodule

// File: tb/tb_prio_irq_encoder.sv
module tb_prio_irq_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ei_bar = 1'b0;
  logic       rdy = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] req_bar = 8'hFF;
`ifdef PRIO_MASK_EN
  logic [7:0] mask = 8'h00;
`endif
  logic       vld, gs_bar, eo_bar, ovf;
  logic [2:0] y_bar;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prio_irq_encoder #(.WIDTH_IN(8), .WIDTH_OUT(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ei_bar  (ei_bar),
    .req_bar (req_bar),
    .rdy     (rdy),
    .clr_ovf (clr_ovf),
`ifdef PRIO_MASK_EN
    .mask    (mask),
`endif
    .vld     (vld),
    .y_bar   (y_bar),
    .gs_bar  (gs_bar),
    .eo_bar  (eo_bar),
    .ovf     (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request lines, pending set, one presented index.
  bit m_pend[8] = '{default: 1'b0};
  bit m_prev[8] = '{default: 1'b1};
  bit m_busy = 1'b0;
  bit m_ovf = 1'b0;
  int m_cur = 0;
  int sb[$];
  logic [2:0] acc[$];

  function automatic bit is_masked(input int i);
`ifdef PRIO_MASK_EN
    return mask[i];
`else
    return (i < 0);
`endif
  endfunction

  function automatic int top_eligible();
    for (int i = 7; i >= 0; i--) begin
      if (m_pend[i] && !is_masked(i)) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int clr;
    int win;
    bit fell;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[i] = 1'b0;
        m_prev[i] = 1'b1;
      end
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_cur  = 0;
      sb.delete();
    end else begin
      clr = -1;
      win = top_eligible();
      if (m_busy && rdy) begin
        clr = m_cur;
        m_busy = 1'b0;
      end else if (!m_busy && !ei_bar && win >= 0) begin
        m_busy = 1'b1;
        m_cur  = win;
        sb.push_back(7 - win);
      end
      if (clr_ovf) m_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        fell = m_prev[i] && !req_bar[i];
        if (fell && m_pend[i] && i != clr) m_ovf = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        fell = m_prev[i] && !req_bar[i];
        if (i == clr) m_pend[i] = 1'b0;
        if (fell) m_pend[i] = 1'b1;
        m_prev[i] = req_bar[i];
      end
    end
  end

  // Monitor: compares outputs mid-cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    bit any_e;
    int exp_y;
    any_e = (top_eligible() >= 0);
    chk("vld", {31'd0, vld}, {31'd0, m_busy});
    chk("gs_bar", {31'd0, gs_bar}, {31'd0, !(!ei_bar && any_e)});
    chk("eo_bar", {31'd0, eo_bar}, {31'd0, !(!ei_bar && !any_e)});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (m_busy) chk("y_bar_hold", {29'd0, y_bar}, 32'(7 - m_cur));
    if (vld === 1'b1 && rdy) begin
      acc.push_back(y_bar);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_y = sb.pop_front();
        chk("y_bar_accept", {29'd0, y_bar}, 32'(exp_y));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_gs", {31'd0, gs_bar}, 32'd1);
    chk("rst_eo", {31'd0, eo_bar}, 32'd0);
    chk("rst_y", {29'd0, y_bar}, 32'd7);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // single request, consumer stalls
    req_bar = 8'hFB;
    cyc(1);
    rdy = 1'b0;
    cyc(7);
    chk("t2_y", {29'd0, y_bar}, 32'd5);
    rdy = 1'b1;
    cyc(1);
    rdy = 1'b0;
    req_bar = 8'hFF;
    cyc(3);
    chk("t2_gs", {31'd0, gs_bar}, 32'd1);

    // three simultaneous requests
    acc.delete();
    req_bar = 8'h9D;
    rdy = 1'b1;
    cyc(9);
    req_bar = 8'hFF;
    cyc(2);
    chk("t3_count", acc.size(), 32'd3);
    if (acc.size() == 3) begin
      chk("t3_first", {29'd0, acc[0]}, 32'd1);
      chk("t3_second", {29'd0, acc[1]}, 32'd2);
      chk("t3_third", {29'd0, acc[2]}, 32'd6);
    end

    // overrun on bit 3
    rdy = 1'b0;
    req_bar = 8'hF7; cyc(1);
    req_bar = 8'hFF; cyc(1);
    req_bar = 8'hF7; cyc(1);
    req_bar = 8'hFF; cyc(2);
    chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
    clr_ovf = 1'b1; cyc(1);
    clr_ovf = 1'b0; cyc(1);
    chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);
    rdy = 1'b1; cyc(3);
    rdy = 1'b0;

    // disabled stage
    ei_bar = 1'b1;
    req_bar = 8'hEF; cyc(1);
    req_bar = 8'hFF; cyc(4);
    chk("t5_vld", {31'd0, vld}, 32'd0);
    chk("t5_gs", {31'd0, gs_bar}, 32'd1);
    chk("t5_eo", {31'd0, eo_bar}, 32'd1);
    acc.delete();
    ei_bar = 1'b0;
    rdy = 1'b1;
    cyc(4);
    chk("t5_count", acc.size(), 32'd1);
    if (acc.size() == 1) chk("t5_idx", {29'd0, acc[0]}, 32'd3);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) req_bar[b] = ~req_bar[b];
      end
      rdy     = ($urandom_range(0, 2) != 0);
      ei_bar  = ($urandom_range(0, 9) == 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      cyc(1);
    end
    req_bar = 8'hFF;
    ei_bar  = 1'b0;
    clr_ovf = 1'b0;
    rdy     = 1'b1;
    cyc(24);
    rdy = 1'b0;
    cyc(2);

    // async reset while presenting
    req_bar = 8'h7E; cyc(1);
    req_bar = 8'hFF; cyc(3);
    chk("t6_pre_vld", {31'd0, vld}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_vld", {31'd0, vld}, 32'd0);
    chk("t6_gs", {31'd0, gs_bar}, 32'd1);
    chk("t6_eo", {31'd0, eo_bar}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

`ifdef PRIO_MASK_EN
    mask = 8'h80;
    req_bar = 8'h7E; cyc(1);
    req_bar = 8'hFF; cyc(2);
    chk("mask_y", {29'd0, y_bar}, 32'd7);
    mask = 8'h00;
`endif

    rdy = 1'b1;
    cyc(24);
    chk("sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
